step_sequencer: RTL
===================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 SHALL have parameter STEP_W, default 3: T-state index width; MAX_STEPS = 2**STEP_W.
REQ-002 SHALL have parameter CNT_W, default 16: retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port run  input  1  level; when high, the sequencer fetches and executes instructions.
REQ-006 SHALL have port halt_req  input  1  level; sampled in the last step; requests stop after the current instruction.
REQ-007 SHALL have port exec_last  input  STEP_W  index of the final T-state of the decoded instruction; sampled in T3.
REQ-008 SHALL have port mem_req  input  1  current execute step needs a memory read.
REQ-009 SHALL have port mem_ready  input  1  memory data valid this cycle.
REQ-010 SHALL have port t_onehot  output  MAX_STEPS  one-hot current T-state; all zero when not stepping.
REQ-011 SHALL have port step  output  STEP_W  binary current T-state index.
REQ-012 SHALL have port busy  output  1  high in FETCH, EXEC and WAIT.
REQ-013 SHALL have port waiting  output  1  high while stalled on mem_ready.
REQ-014 SHALL have port instr_done  output  1  one-cycle pulse in the cycle after the last step completes.
REQ-015 SHALL have port halted  output  1  high in HALT.
REQ-016 SHALL have port instr_count  output  CNT_W  count of retired instructions.

Function
REQ-017 SHALL implement states IDLE, FETCH (T0-T2), EXEC (T3..last), WAIT, HALT.
REQ-018 SHALL go IDLE->FETCH with step=0 on the first edge with run=1.
REQ-019 SHALL advance T0->T1->T2->T3 one step per clock, except as stated in REQ-020.
REQ-020 SHALL, in T1 (fetch read), enter WAIT and hold step=1 while mem_ready=0, and advance on the first edge with mem_ready=1.
REQ-021 SHALL, in any execute step with mem_req=1 and mem_ready=0, hold the step with waiting=1.
REQ-022 SHALL, when mem_req and mem_ready are both high in the same cycle, advance with no stall.
REQ-023 SHALL latch last = clamp(exec_last, 3, MAX_STEPS-1) at the end of T3.
REQ-024 SHALL, after step==last completes, pulse instr_done and increment instr_count by 1 modulo 2**CNT_W (wraps to 0).
REQ-025 SHALL choose the next state by priority: halt_req=1 -> HALT; else run=1 -> T0 (back-to-back, no bubble); else -> IDLE.
REQ-026 SHALL ignore run=0 and halt_req mid-instruction: the current instruction always completes.
REQ-027 SHALL leave HALT only via reset.
REQ-028 SHALL drive t_onehot[step]=1 only in FETCH, EXEC and WAIT, and zero otherwise.
REQ-029 SHALL register all outputs, with no combinational input-to-output path.

Reset
REQ-030 SHALL, on reset=0 at any time including mid-instruction or WAIT, force IDLE immediately (asynchronous assert).
REQ-031 SHALL hold these values in reset: step=0, t_onehot=0, busy=0, waiting=0, instr_done=0, halted=0, instr_count=0, last=3.
REQ-032 SHALL release reset synchronously with respect to clk, the first transition occurring on the first rising edge after deassertion.

Configuration
REQ-033 SHALL, with macro STEP_SEQUENCER_SINGLE_STEP_EN defined, add port step_req (input, 1).
REQ-034 SHALL, with the macro defined, advance each T-state transition only on a cycle with step_req=1; WAIT still additionally requires mem_ready, and IDLE->T0 also requires step_req.
REQ-035 SHALL, with the macro undefined, omit the port and advance every cycle as specified above.

Verification
REQ-036 SHALL cover: run=1, exec_last=5, mem_ready=1 always -> t_onehot 0x01,0x02,0x04,0x08,0x10,0x20 on consecutive edges; instr_done pulse; instr_count=1; next cycle t_onehot=0x01.
REQ-037 SHALL cover: mem_ready=0 for 4 cycles in T1 -> step=1 and waiting=1 for 4 cycles; T2 on the edge after mem_ready=1.
REQ-038 SHALL cover: exec_last=1 -> last=3, instruction is 4 cycles; exec_last=7 -> 8 cycles.
REQ-039 SHALL cover: halt_req=1 from T3 with exec_last=4 -> completes T4, instr_done, halted=1, busy=0, held until reset.
REQ-040 SHALL cover: reset=0 asserted mid-T4 between edges -> outputs zero immediately; run=1 after release -> T0 on the first edge.
REQ-041 SHALL cover: instr_count preset path with CNT_W=4 over 16 instructions -> wraps to 0; single-step build: step_req pulsed every 3rd cycle -> one T-state advance per pulse.

Source files
------------

// File: rtl/step_sequencer.sv
// step_sequencer: T-state sequencer for a simple instruction engine.
//   FETCH covers T0..T2, EXEC covers T3..last. The fetch read in T1 and any
//   execute step with mem_req stall in WAIT until mem_ready. Every output
//   is a flop, so there is no combinational path from an input to an output.
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous assert, active low
//   run          fetch/execute enable (level)
//   halt_req     stop after the current instruction (sampled in last step)
//   exec_last    final T-state of the decoded instruction (sampled in T3)
//   mem_req      current execute step needs a memory read
//   mem_ready    memory data valid this cycle
//   step_req     single-step advance strobe (only with the macro below)
//   t_onehot     one-hot current T-state, zero when not stepping
//   step         binary current T-state
//   busy         FETCH, EXEC or WAIT
//   waiting      stalled on mem_ready
//   instr_done   one-cycle pulse after the last step completes
//   halted       in HALT (left only through reset)
//   instr_count  retired instructions, wraps modulo 2**CNT_W
//
// Build option: define STEP_SEQUENCER_SINGLE_STEP_EN to add step_req and
// gate every T-state advance on it.
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | not stepping, waiting for run
// S_FETCH | T0..T2, instruction fetch
// S_EXEC  | T3..last, execute
// S_WAIT  | stalled in T1 or an execute step until mem_ready
// S_HALT  | stopped after halt_req, exit only via reset
module step_sequencer #(
  parameter int STEP_W = 3,
  parameter int CNT_W  = 16,
  localparam int MAX_STEPS = 2 ** STEP_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic                 halt_req,
  input  logic [STEP_W-1:0]    exec_last,
  input  logic                 mem_req,
  input  logic                 mem_ready,
`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
  input  logic                 step_req,
`endif
  output logic [MAX_STEPS-1:0] t_onehot,
  output logic [STEP_W-1:0]    step,
  output logic                 busy,
  output logic                 waiting,
  output logic                 instr_done,
  output logic                 halted,
  output logic [CNT_W-1:0]     instr_count
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

  state_t               r_state, w_state_nxt;
  logic [STEP_W-1:0]    r_step, w_step_nxt;
  logic [STEP_W-1:0]    r_last, w_last_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic                 r_done, w_done_nxt;
  logic [MAX_STEPS-1:0] r_onehot, w_onehot_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_waiting, w_waiting_nxt;
  logic                 r_halted, w_halted_nxt;

  logic                 w_adv;
  logic                 w_stall;
  logic                 w_go;
  logic                 w_at_last;
  logic [STEP_W-1:0]    w_exec_clamped;
  logic [STEP_W-1:0]    w_last_eff;

`ifdef STEP_SEQUENCER_SINGLE_STEP_EN
  assign w_adv = step_req;
`else
  assign w_adv = 1'b1;
`endif

  // Upper clamp is implicit: exec_last cannot exceed MAX_STEPS-1.
  assign w_exec_clamped = (exec_last < STEP_W'(3)) ? STEP_W'(3) : exec_last;
  // In T3 the latched value is not yet updated, so compare against the input.
  assign w_last_eff = (r_step == STEP_W'(3)) ? w_exec_clamped : r_last;
  assign w_at_last  = (r_step == w_last_eff);
  assign w_stall    = !mem_ready &&
                      ((r_state == S_FETCH && r_step == STEP_W'(1)) ||
                       (r_state == S_EXEC && mem_req));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_last    <= STEP_W'(3);
      r_count   <= '0;
      r_done    <= 1'b0;
      r_onehot  <= '0;
      r_busy    <= 1'b0;
      r_waiting <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_step    <= w_step_nxt;
      r_last    <= w_last_nxt;
      r_count   <= w_count_nxt;
      r_done    <= w_done_nxt;
      r_onehot  <= w_onehot_nxt;
      r_busy    <= w_busy_nxt;
      r_waiting <= w_waiting_nxt;
      r_halted  <= w_halted_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_step_nxt  = r_step;
    w_last_nxt  = r_last;
    w_count_nxt = r_count;
    w_done_nxt  = 1'b0;
    w_go        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run && w_adv) begin
          w_state_nxt = S_FETCH;
          w_step_nxt  = '0;
        end
      end
      S_FETCH, S_EXEC: begin
        if (w_stall) w_state_nxt = S_WAIT;
        else         w_go        = w_adv;
      end
      S_WAIT:  w_go        = mem_ready && w_adv;
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_go) begin
      if (r_step == STEP_W'(3)) w_last_nxt = w_exec_clamped;
      if (w_at_last) begin
        w_done_nxt  = 1'b1;
        w_count_nxt = r_count + CNT_W'(1);
        w_step_nxt  = '0;
        if (halt_req)  w_state_nxt = S_HALT;
        else if (run)  w_state_nxt = S_FETCH;
        else           w_state_nxt = S_IDLE;
      end else begin
        w_step_nxt  = r_step + STEP_W'(1);
        w_state_nxt = (r_step < STEP_W'(2)) ? S_FETCH : S_EXEC;
      end
    end
  end

  // Outputs are decoded from the next state so they land in flops.
  always_comb begin
    w_onehot_nxt  = '0;
    w_busy_nxt    = (w_state_nxt == S_FETCH) || (w_state_nxt == S_EXEC) ||
                    (w_state_nxt == S_WAIT);
    w_waiting_nxt = (w_state_nxt == S_WAIT);
    w_halted_nxt  = (w_state_nxt == S_HALT);
    if (w_busy_nxt) w_onehot_nxt[w_step_nxt] = 1'b1;
  end

  assign t_onehot    = r_onehot;
  assign step        = r_step;
  assign busy        = r_busy;
  assign waiting     = r_waiting;
  assign instr_done  = r_done;
  assign halted      = r_halted;
  assign instr_count = r_count;

endmodule
